jpeg_bit_writer: RTL and testbench

Entropy-stage bit packer for the JPEG encoder. It accepts variable-length code fields (Huffman codes from the DC/AC code ROMs, followed by the amplitude bits) and packs them MSB-first into bytes. Every 0xFF data byte is followed by a stuffed 0x00. On flush it pads the final partial byte with 1s. It sits directly downstream of the Huffman code/length ROM lookups and feeds the byte sink (output FIFO / ESP32 interface).

---
 rtl/jpeg_enc_pkg.sv | 8 +
 rtl/jpeg_bit_writer.sv | 77 +++++++
 tb/tb_jpeg_bit_writer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_enc_pkg.sv
// jpeg_enc_pkg: shared constants and FSM state type for the JPEG entropy stage
package jpeg_enc_pkg;
  localparam int JPEG_ACC_W = 32;
  localparam int JPEG_MAX_CODE_LEN = 16;
  localparam logic [7:0] JPEG_STUFF_TRIGGER = 8'hFF;
  localparam logic [7:0] JPEG_STUFF_BYTE = 8'h00;
  typedef enum logic {RUN, DRAIN} state_t;
endpackage

// File: rtl/jpeg_bit_writer.sv
// jpeg_bit_writer: packs in_bits/in_len fields MSB-first into out_data bytes with 0xFF->0x00 stuffing, 1-padding flush (flush_done) and byte_cnt
import jpeg_enc_pkg::*;

module jpeg_bit_writer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_bits,
  input  logic [4:0]       in_len,
  input  logic             in_flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             flush_done,
  output logic [CNT_W-1:0] byte_cnt
);
  logic [JPEG_ACC_W-1:0] acc, acc_b, acc_i, acc_n;
  logic [5:0] cnt, cnt_e, cnt_i, cnt_n;
  logic [4:0] len;
  logic [2:0] pad;
  logic stuff, stuff_n, pop, pop_d, acpt, fl;
  logic [CNT_W-1:0] byte_cnt_n;
  state_t state, state_n;

  function automatic logic [JPEG_ACC_W-1:0] ins(input logic [JPEG_ACC_W-1:0] a, input logic [15:0] b,
                                                input logic [4:0] l, input logic [5:0] c);
    return a | (({16'h0, b} & ((32'h1 << l) - 32'h1)) << (6'd32 - c - {1'b0, l}));
  endfunction

  assign in_ready = cnt <= 6'd16 && state == RUN;
  assign out_valid = stuff || cnt >= 6'd8;
  assign out_data = stuff ? JPEG_STUFF_BYTE : acc[31:24];
  assign flush_done = state == DRAIN && cnt == 6'd0 && !stuff;

  always_comb begin
    pop = out_valid && out_ready;
    pop_d = pop && !stuff;
    acpt = in_valid && in_ready;
    fl = acpt && in_flush;
    len = in_len > 5'(JPEG_MAX_CODE_LEN) ? 5'(JPEG_MAX_CODE_LEN) : in_len;
    acc_b = pop_d ? acc << 8 : acc;
    cnt_e = pop_d ? cnt - 6'd8 : cnt;
    acc_i = acpt ? ins(acc_b, in_bits, len, cnt_e) : acc_b;
    cnt_i = acpt ? cnt_e + {1'b0, len} : cnt_e;
    pad = 3'd0 - cnt_i[2:0];
    acc_n = fl ? ins(acc_i, 16'hFFFF, {2'b0, pad}, cnt_i) : acc_i;
    cnt_n = fl ? cnt_i + {3'b0, pad} : cnt_i;
    stuff_n = pop_d ? acc[31:24] == JPEG_STUFF_TRIGGER : (pop ? 1'b0 : stuff);
    byte_cnt_n = pop ? byte_cnt + CNT_W'(1) : byte_cnt;
    state_n = state == RUN ? (fl ? DRAIN : RUN) : (flush_done ? RUN : DRAIN);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
      stuff <= 1'b0;
      byte_cnt <= '0;
      state <= RUN;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      stuff <= 1'b0;
      byte_cnt <= '0;
      state <= RUN;
    end else begin
      acc <= acc_n;
      cnt <= cnt_n;
      stuff <= stuff_n;
      byte_cnt <= byte_cnt_n;
      state <= state_n;
    end
endmodule

// File: tb/tb_jpeg_bit_writer.sv
// tb_jpeg_bit_writer: directed self-checking bench for jpeg_bit_writer
module tb_jpeg_bit_writer;
  logic clk = 0, reset_n = 0, clr = 0, in_valid = 0, in_flush = 0, out_ready = 0;
  logic [15:0] in_bits = 0;
  logic [4:0] in_len = 0;
  logic in_ready, out_valid, flush_done;
  logic [7:0] out_data;
  logic [23:0] byte_cnt;
  int checks = 0, errors = 0, fd_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] exp_q[$];

  jpeg_bit_writer #(.CNT_W(24)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .in_len(in_len), .in_flush(in_flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .flush_done(flush_done), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && !clr && out_valid && out_ready) q.push_back(out_data);
    if (reset_n && !clr && flush_done) fd_cnt++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] b, input logic [4:0] l, input logic f);
    int n = 0;
    in_valid = 1; in_bits = b; in_len = l; in_flush = f;
    while (!in_ready && n < 100) begin step; n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL push_timeout bits %h in_ready stuck at %b", b, in_ready); end
    step;
    in_valid = 0; in_flush = 0;
  endtask

  task automatic wait_bytes(input int n);
    int c = 0;
    while (q.size() < n && c < 200) begin step; c++; end
    checks++;
    if (c >= 200) begin errors++; $display("FAIL byte_timeout got %0d bytes need %0d", q.size(), n); end
  endtask

  task automatic do_clr;
    out_ready = 0; clr = 1;
    step;
    clr = 0;
    q.delete(); exp_q.delete(); fd_cnt = 0;
  endtask

  task automatic cmp_bytes(input string name);
    checks++;
    if (q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count got %0d exp %0d", name, q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_byte%0d got %h exp %h", name, i, q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({in_ready, out_valid, out_data, flush_done, byte_cnt} !== {1'b1, 1'b0, 8'h00, 1'b0, 24'h0}) begin
      errors++; $display("FAIL reset got rdy %b vld %b data %h fd %b cnt %h exp 1 0 00 0 0", in_ready, out_valid, out_data, flush_done, byte_cnt);
    end
    reset_n = 1;
    step;
  endtask

  task automatic test_pack;
    do_clr;
    out_ready = 1;
    push(16'h001F, 5'd5, 0);
    push(16'h0002, 5'd3, 0);
    wait_bytes(1); step; step;
    exp_q = '{8'hFA};
    cmp_bytes("pack");
    checks++;
    if (byte_cnt !== 24'd1) begin errors++; $display("FAIL pack_byte_cnt got %0d exp 1", byte_cnt); end
  endtask

  task automatic test_stuff;
    do_clr;
    out_ready = 1;
    push(16'hFFFF, 5'd16, 0);
    wait_bytes(4); step; step;
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    cmp_bytes("stuff");
    checks++;
    if (byte_cnt !== 24'd4) begin errors++; $display("FAIL stuff_byte_cnt got %0d exp 4", byte_cnt); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stuff_idle out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_flush;
    do_clr;
    out_ready = 1;
    push(16'h0005, 5'd3, 1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_drain_ready got %b exp 0", in_ready); end
    wait_bytes(1); step; step; step;
    exp_q = '{8'hBF};
    cmp_bytes("flush");
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL flush_done_pulses got %0d exp 1", fd_cnt); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_run_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_backpressure;
    do_clr;
    push(16'hAAAA, 5'd16, 0);
    push(16'h5555, 5'd16, 0);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    step;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL bp_hold got vld %b data %h exp 1 aa", out_valid, out_data); end
    out_ready = 1;
    wait_bytes(4); step;
    exp_q = '{8'hAA, 8'hAA, 8'h55, 8'h55};
    cmp_bytes("bp");
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_clamp;
    do_clr;
    out_ready = 1;
    push(16'hFFFF, 5'd20, 0);
    push(16'hFFF0, 5'd4, 1);
    wait_bytes(5); step; step; step;
    exp_q = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h0F};
    cmp_bytes("clamp");
    checks++;
    if (byte_cnt !== 24'd5) begin errors++; $display("FAIL clamp_byte_cnt got %0d exp 5", byte_cnt); end
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL clamp_flush_done got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_back_to_back;
    do_clr;
    out_ready = 1;
    push(16'h0012, 5'd8, 0);
    push(16'h0034, 5'd8, 0);
    push(16'h00FF, 5'd8, 0);
    push(16'h0056, 5'd8, 0);
    wait_bytes(5); step; step;
    exp_q = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56};
    cmp_bytes("b2b");
    checks++;
    if (byte_cnt !== 24'd5) begin errors++; $display("FAIL b2b_byte_cnt got %0d exp 5", byte_cnt); end
  endtask

  task automatic test_clr;
    out_ready = 0;
    push(16'hABCD, 5'd16, 0);
    clr = 1;
    step;
    clr = 0;
    checks++;
    if ({out_valid, byte_cnt, in_ready} !== {1'b0, 24'h0, 1'b1}) begin
      errors++; $display("FAIL clr got vld %b cnt %0d rdy %b exp 0 0 1", out_valid, byte_cnt, in_ready);
    end
  endtask

  task automatic test_zero_flush;
    do_clr;
    out_ready = 1;
    push(16'h0000, 5'd0, 1);
    checks++;
    if ({in_ready, flush_done} !== 2'b01) begin errors++; $display("FAIL zflush_drain got rdy %b fd %b exp 0 1", in_ready, flush_done); end
    step; step;
    checks++;
    if (fd_cnt != 1 || q.size() != 0) begin errors++; $display("FAIL zflush got pulses %0d bytes %0d exp 1 0", fd_cnt, q.size()); end
  endtask

  task automatic test_reset_drain;
    do_clr;
    push(16'h1234, 5'd16, 1);
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL rd_pre got rdy %b vld %b exp 0 1", in_ready, out_valid); end
    #1 reset_n = 0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, flush_done, byte_cnt} !== {1'b1, 1'b0, 8'h00, 1'b0, 24'h0}) begin
      errors++; $display("FAIL rd_async got rdy %b vld %b data %h fd %b cnt %h exp 1 0 00 0 0", in_ready, out_valid, out_data, flush_done, byte_cnt);
    end
    step;
    reset_n = 1;
    q.delete(); fd_cnt = 0;
    out_ready = 1;
    push(16'h000A, 5'd4, 1);
    wait_bytes(1); step; step; step;
    exp_q = '{8'hAF};
    cmp_bytes("rd");
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL rd_flush_done got %0d exp 1", fd_cnt); end
    checks++;
    if (byte_cnt !== 24'd1) begin errors++; $display("FAIL rd_byte_cnt got %0d exp 1", byte_cnt); end
  endtask

  initial begin
    test_reset;
    test_pack;
    test_stuff;
    test_flush;
    test_backpressure;
    test_clamp;
    test_back_to_back;
    test_clr;
    test_zero_flush;
    test_reset_drain;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
